// File: rtl/pwl_pkg.sv
// Shared definitions for the streaming PWL activation: mode encodings,
// pipeline depth, the ONE constant and a generic clip helper.
package pwl_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_HT2X   = 2'd1,
    MODE_LEAKY  = 2'd2,
    MODE_HT     = 2'd3
  } mode_e;

  localparam int STAGES = 2;

  function automatic longint pwl_one(input int frac_w);
    return longint'(1) <<< frac_w;
  endfunction

  function automatic longint sat_clip(input longint v, input longint lo, input longint hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/pwl_lane.sv
// One lane of the PWL datapath: S1 holds mode plus the widened intermediate,
// S2 holds the clamped/saturated result and its clamp flag.
module pwl_lane
  import pwl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 12,
  parameter int LEAKY_K = 410
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s1_en,
  input  logic                     s2_en,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y,
  output logic                     sat
);

  localparam int W = DATA_W + FRAC_W + 1;
  localparam longint ONE  = pwl_one(FRAC_W);
  localparam longint DMAX = (longint'(1) <<< (DATA_W-1)) - 1;
  localparam longint DMIN = -(longint'(1) <<< (DATA_W-1));
  localparam logic signed [W-1:0] KW = W'(LEAKY_K);

  logic signed [W-1:0]      xw, wide_d, s1_w;
  mode_e                    s1_mode;
  longint                   v, r;
  logic                     sat_d;
  logic signed [DATA_W-1:0] y_d;

  assign xw = W'(x);

  // Positive leaky inputs are pre-scaled by ONE so S2 applies one uniform shift.
  always_comb begin
    wide_d = xw;
    case (mode_e'(mode))
      MODE_HT2X:  wide_d = xw <<< 1;
      MODE_LEAKY: wide_d = x[DATA_W-1] ? xw * KW : xw <<< FRAC_W;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode <= MODE_BYPASS;
      s1_w    <= '0;
    end else if (s1_en) begin
      s1_mode <= mode_e'(mode);
      s1_w    <= wide_d;
    end
  end

  always_comb begin
    v     = longint'(s1_w);
    r     = sat_clip(v, DMIN, DMAX);
    sat_d = 1'b0;
    case (s1_mode)
      MODE_HT2X, MODE_HT: begin
        r     = sat_clip(v, -ONE, ONE);
        sat_d = (v > ONE) || (v < -ONE);
      end
      MODE_LEAKY: r = sat_clip(v >>> FRAC_W, DMIN, DMAX);
      default:    ;
    endcase
  end

  assign y_d = DATA_W'(r);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      sat <= 1'b0;
    end else if (s2_en) begin
      y   <= y_d;
      sat <= sat_d;
    end
  end

endmodule

// File: rtl/pwl_activation_stream.sv
// Two-stage, LANES-wide PWL activation over valid/ready. Optional saturation
// event counter (sat_clr/sat_count) is built when PWL_SAT_COUNT_EN is defined.
module pwl_activation_stream
  import pwl_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int FRAC_W  = 12,
  parameter int LANES   = 4,
  parameter int LEAKY_K = 410
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_mode,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*DATA_W-1:0]   out_data,
  output logic [LANES-1:0]          out_sat
`ifdef PWL_SAT_COUNT_EN
  ,
  input  logic                      sat_clr,
  output logic [15:0]               sat_count
`endif
);

  logic [STAGES:1]                vld_pipe;
  logic                           s1_en, s2_en, s2_adv;
  logic [LANES-1:0][DATA_W-1:0]   din, dout;

  // S1 may refill in the same cycle it hands its beat to a draining S2.
  assign s2_adv    = !vld_pipe[2] || out_ready;
  assign in_ready  = !vld_pipe[1] || s2_adv;
  assign s1_en     = in_valid && in_ready;
  assign s2_en     = vld_pipe[1] && s2_adv;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else begin
      if (in_ready) vld_pipe[1] <= in_valid;
      if (s2_adv)   vld_pipe[2] <= vld_pipe[1];
    end
  end

  assign din      = in_data;
  assign out_data = dout;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    pwl_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .LEAKY_K(LEAKY_K)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .s1_en(s1_en),
      .s2_en(s2_en),
      .mode (in_mode),
      .x    (din[g]),
      .y    (dout[g]),
      .sat  (out_sat[g])
    );
  end

`ifdef PWL_SAT_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sat_count <= '0;
    else if (sat_clr)
      sat_count <= '0;
    else if (out_valid && out_ready && |out_sat && sat_count != 16'hFFFF)
      sat_count <= sat_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pwl_activation_stream.sv
// Directed bench for pwl_activation_stream: per-mode vectors, backpressure,
// mixed-mode streaming, throughput and mid-stream reset.
module tb_pwl_activation_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_mode;
  logic [63:0] in_data, out_data;
  logic [3:0]  out_sat;
`ifdef PWL_SAT_COUNT_EN
  logic        sat_clr;
  logic [15:0] sat_count;
`endif

  pwl_activation_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_sat  (out_sat)
`ifdef PWL_SAT_COUNT_EN
    ,
    .sat_clr  (sat_clr),
    .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  // beat table: mode, input, expected output, expected sat
  logic [1:0]  tm [12];
  logic [63:0] tx [12];
  logic [63:0] ty [12];
  logic [3:0]  ts [12];

  task automatic setb(input int i, input int m, input logic [63:0] x,
                      input logic [63:0] y, input logic [3:0] s);
    tm[i] = 2'(m); tx[i] = x; ty[i] = y; ts[i] = s;
  endtask

  int drv_idx, drv_end, nout;
  bit pend;
  int expq[$];

  // One cycle of stream traffic: drive, check any output handshake, clock.
  task automatic cyc(input int vp, input int rp);
    bit acc;
    int k;
    if (drv_idx < drv_end) begin
      if (!pend) pend = ($urandom_range(0, 99) < vp);
      in_valid = pend;
      in_mode  = tm[drv_idx];
      in_data  = tx[drv_idx];
    end else begin
      in_valid = 1'b0;
      pend     = 1'b0;
    end
    out_ready = ($urandom_range(0, 99) < rp);
    #1;
    if (out_valid && out_ready) begin
      nout++;
      if (expq.size() > 0) begin
        k = expq.pop_front();
        chk($sformatf("s_data%0d", k), out_data, ty[k]);
        chk($sformatf("s_sat%0d", k), 64'(out_sat), 64'(ts[k]));
      end
    end
    acc = in_valid && in_ready;
    @(posedge clk); #1;
    if (acc) begin
      expq.push_back(drv_idx);
      drv_idx++;
      pend = 1'b0;
    end
  endtask

  task automatic drain(input string tag, input int vp, input int rp, input int exp_n);
    int guard = 0;
    while ((drv_idx < drv_end || expq.size() > 0) && guard < 300) begin
      cyc(vp, rp);
      guard++;
    end
    chk({tag, "_left"}, 64'(expq.size()), 64'd0);
    chk({tag, "_nout"}, 64'(nout), 64'(exp_n));
  endtask

  task automatic send_one(input string tag, input int m, input logic [63:0] x,
                          input logic [63:0] y, input logic [3:0] s);
    in_valid = 1'b1; in_mode = 2'(m); in_data = x; out_ready = 1'b1;
    #1;
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = '0;
    chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, out_data, y);
    chk({tag, "_sat"}, 64'(out_sat), 64'(s));
    @(posedge clk); #1;
    chk({tag, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b0;
`ifdef PWL_SAT_COUNT_EN
    sat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(out_valid), 64'd0);
    chk("rst_data", out_data, 64'd0);
    chk("rst_sat", 64'(out_sat), 64'd0);
    #2 rst_n = 1'b1;
    #1 chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
`ifdef PWL_SAT_COUNT_EN
    chk("cnt_rst", 64'(sat_count), 64'd0);
`endif

    send_one("ht2x", 1, pk(1024, 2048, 3276, -6144), pk(2048, 4096, 4096, -4096), 4'b1100);
    send_one("leaky", 2, pk(4096, -4096, -1, 0), pk(4096, -410, -1, 0), 4'b0000);
    send_one("ht", 3, pk(8192, -8192, 4096, 0), pk(4096, -4096, 4096, 0), 4'b0011);
    send_one("byp", 0, pk(32767, -32768, 5, -5), pk(32767, -32768, 5, -5), 4'b0000);
`ifdef PWL_SAT_COUNT_EN
    chk("cnt_two", 64'(sat_count), 64'd2);
`endif

    setb(0, 1, pk(100, -100, 2047, 2049),      pk(200, -200, 4094, 4096),       4'b1000);
    setb(1, 2, pk(-8192, 10, -10, 32767),      pk(-820, 10, -2, 32767),         4'b0000);
    setb(2, 3, pk(4097, -4097, -4096, 0),      pk(4096, -4096, -4096, 0),       4'b0011);
    setb(3, 0, pk(-32768, 1, 2, 3),            pk(-32768, 1, 2, 3),             4'b0000);
    setb(4, 1, pk(-32768, 32767, -2048, 0),    pk(-4096, 4096, -4096, 0),       4'b0011);
    setb(5, 2, pk(-32768, 1, -4095, -4097),    pk(-3280, 1, -410, -411),        4'b0000);
    setb(6, 3, pk(-1, 1, 32767, -32768),       pk(-1, 1, 4096, -4096),          4'b1100);
    setb(7, 0, pk(1234, -1234, 0, -1),         pk(1234, -1234, 0, -1),          4'b0000);
    setb(8, 1, pk(-2049, 2048, -1, 1),         pk(-4096, 4096, -2, 2),          4'b0001);
    setb(9, 2, pk(-100, 100, -4096, 8191),     pk(-11, 100, -410, 8191),        4'b0000);
    setb(10, 3, pk(4096, -4096, 4095, -4095),  pk(4096, -4096, 4095, -4095),    4'b0000);
    setb(11, 0, pk(0, 0, 0, 7),                pk(0, 0, 0, 7),                  4'b0000);

    // backpressure: two beats fill the pipe, the third must wait
    drv_idx = 0; drv_end = 4; nout = 0; pend = 1'b0; expq.delete();
    cyc(100, 0);
    cyc(100, 0);
    chk("bp_acc2", 64'(drv_idx), 64'd2);
    in_valid = 1'b1; in_mode = tm[2]; in_data = tx[2]; out_ready = 1'b0; pend = 1'b1;
    #1;
    chk("bp_full", 64'(in_ready), 64'd0);
    chk("bp_vld", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", i), out_data, ty[0]);
      chk($sformatf("bp_sathold%0d", i), 64'(out_sat), 64'(ts[0]));
      chk($sformatf("bp_rdy%0d", i), 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp_rdy_comb", 64'(in_ready), 64'd1);
    drain("bp", 100, 100, 4);

    // mixed modes, random in_valid, always ready
    drv_idx = 4; drv_end = 12; nout = 0; pend = 1'b0; expq.delete();
    drain("mix", 60, 100, 8);

    // mixed modes with random downstream stalls
    drv_idx = 4; drv_end = 12; nout = 0; pend = 1'b0; expq.delete();
    drain("mixbp", 70, 50, 8);

    // full rate: 8 beats back to back drain in 8 + 2 cycles
    drv_idx = 4; drv_end = 12; nout = 0; pend = 1'b0; expq.delete();
    cnt = 0;
    while ((drv_idx < drv_end || expq.size() > 0) && cnt < 100) begin
      cyc(100, 100);
      cnt++;
    end
    chk("tput_cycles", 64'(cnt), 64'd10);
    chk("tput_nout", 64'(nout), 64'd8);

    // reset with two beats in flight
    drv_idx = 0; drv_end = 2; nout = 0; pend = 1'b0; expq.delete();
    cyc(100, 0);
    cyc(100, 0);
    chk("mrst_pre_vld", 64'(out_valid), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", 64'(out_valid), 64'd0);
    chk("mrst_data", out_data, 64'd0);
    chk("mrst_sat", 64'(out_sat), 64'd0);
`ifdef PWL_SAT_COUNT_EN
    chk("mrst_cnt", 64'(sat_count), 64'd0);
`endif
    in_valid = 1'b0; pend = 1'b0; expq.delete(); out_ready = 1'b1;
    #2 rst_n = 1'b1;
    #1 chk("mrst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("mrst_stale%0d", i), 64'(out_valid), 64'd0);
    end

`ifdef PWL_SAT_COUNT_EN
    send_one("cnt_ht2x", 1, tx[0], ty[0], ts[0]);
    chk("cnt_one", 64'(sat_count), 64'd1);
    sat_clr = 1'b1;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk("cnt_clr", 64'(sat_count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
